// File: rtl/mem_req_arbiter_pkg.sv
// mem_req_arbiter_pkg
//   Shared types for the fetch/mem request arbiter: FSM state, requester id,
//   memory request mode encodings, the latched request record and the
//   winner-selection helper.
package mem_req_arbiter_pkg;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_RESP = 1'b1
    } arb_state_t;

    // Encoding doubles as an array index in users (fetch = 0, mem = 1).
    typedef enum logic {
        REQ_FETCH = 1'b0,
        REQ_MEM   = 1'b1
    } req_id_t;

    localparam logic MEMREQ_READ  = 1'b0;
    localparam logic MEMREQ_WRITE = 1'b1;

    typedef struct packed {
        logic        mode;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_req_t;

    // Fixed priority: mem wins whenever valid.
    // Round-robin: on a tie, the requester not granted last time wins.
    function automatic req_id_t arb_pick(input logic    fixed_prio,
                                         input logic    f_valid,
                                         input logic    m_valid,
                                         input req_id_t last_grant);
        req_id_t w;
        if (fixed_prio)
            w = m_valid ? REQ_MEM : REQ_FETCH;
        else if (f_valid && m_valid)
            w = (last_grant == REQ_FETCH) ? REQ_MEM : REQ_FETCH;
        else
            w = m_valid ? REQ_MEM : REQ_FETCH;
        return w;
    endfunction

endpackage

// File: rtl/mem_req_arbiter_if.sv
// mem_req_arbiter_if
//   Request/response bundle used for both requester links and the downstream
//   link.
//   Requester link: master = requester (fetch / LSU), slave = arbiter.
//     req_en/req_mode/req_addr/req_wdata/req_wstrb : request pulse + fields
//     pending   : slot occupied
//     resp_en/resp_data : response pulse + registered read data
//     resp_err  : timeout flag (only when ARB_TIMEOUT_EN is defined)
//   Downstream link: dn_master = arbiter, dn_slave = MMU/AXI side. Only the
//     request fields and resp_en/resp_data are used there.
//   Optional macro: ARB_TIMEOUT_EN adds resp_err.
interface mem_req_arbiter_if;

    logic        req_en;
    logic        req_mode;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        pending;
    logic        resp_en;
    logic [31:0] resp_data;
`ifdef ARB_TIMEOUT_EN
    logic        resp_err;
`endif

    modport master (
        output req_en, req_mode, req_addr, req_wdata, req_wstrb,
        input  pending, resp_en, resp_data
`ifdef ARB_TIMEOUT_EN
        , input resp_err
`endif
    );

    modport slave (
        input  req_en, req_mode, req_addr, req_wdata, req_wstrb,
        output pending, resp_en, resp_data
`ifdef ARB_TIMEOUT_EN
        , output resp_err
`endif
    );

    modport dn_master (
        output req_en, req_mode, req_addr, req_wdata, req_wstrb,
        input  resp_en, resp_data
    );

    modport dn_slave (
        input  req_en, req_mode, req_addr, req_wdata, req_wstrb,
        output resp_en, resp_data
    );

endinterface

// File: rtl/mem_req_arbiter_req_slot.sv
// mem_req_arbiter_req_slot
//   One-entry request holding register. A capture pulse loads the request
//   only when the slot is empty; pulses while occupied are dropped. The slot
//   stays valid through grant and clears when its response is delivered.
//   Ports:
//     clk, rstn    : clock, synchronous active-low reset
//     cap_en_i     : request pulse from the requester
//     req_i        : request fields presented with cap_en_i
//     clr_i        : response delivered, free the slot
//     valid_o      : slot occupied
//     req_o        : latched request fields
module mem_req_arbiter_req_slot
    import mem_req_arbiter_pkg::*;
(
    input  logic     clk,
    input  logic     rstn,
    input  logic     cap_en_i,
    input  mem_req_t req_i,
    input  logic     clr_i,
    output logic     valid_o,
    output mem_req_t req_o
);

    logic     valid_q, valid_d;
    mem_req_t req_q, req_d;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            req_q   <= '0;
        end else begin
            valid_q <= valid_d;
            req_q   <= req_d;
        end
    end

    // clr_i only fires for an occupied slot, and capture only for an empty
    // one, so the two never target the same cycle.
    always_comb begin
        valid_d = valid_q;
        req_d   = req_q;
        if (clr_i)
            valid_d = 1'b0;
        if (cap_en_i && !valid_q) begin
            valid_d = 1'b1;
            req_d   = req_i;
        end
    end

    assign valid_o = valid_q;
    assign req_o   = req_q;

endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
//   Shares one downstream memory request port between instruction fetch and
//   the load/store unit. Each requester has a one-deep slot; one downstream
//   transaction is outstanding at a time and its response is routed to the
//   requester that was granted.
//   Parameters:
//     FIXED_PRIO     : 0 = round-robin, 1 = mem always wins
//     TIMEOUT_CYCLES : WAIT_RESP watchdog limit (ARB_TIMEOUT_EN only)
//   Ports:
//     clk, rstn : clock, synchronous active-low reset
//     f_if      : fetch requester link (slave side)
//     m_if      : mem requester link (slave side)
//     d_if      : downstream MMU/AXI link (master side)
//   Optional macro: ARB_TIMEOUT_EN enables the response watchdog and the
//   resp_err flags on f_if/m_if.
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int FIXED_PRIO     = 0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       rstn,
    mem_req_arbiter_if.slave           f_if,
    mem_req_arbiter_if.slave           m_if,
    mem_req_arbiter_if.dn_master       d_if
);

    // The watchdog counter is 16 bits wide.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 1..65535");
    end

    // ---------------- request slots ----------------
    logic     f_valid, m_valid;
    logic     f_clr, m_clr;
    mem_req_t f_slot, m_slot;

    mem_req_arbiter_req_slot u_f_slot (
        .clk      (clk),
        .rstn     (rstn),
        .cap_en_i (f_if.req_en),
        .req_i    ('{f_if.req_mode, f_if.req_addr, f_if.req_wdata, f_if.req_wstrb}),
        .clr_i    (f_clr),
        .valid_o  (f_valid),
        .req_o    (f_slot)
    );

    mem_req_arbiter_req_slot u_m_slot (
        .clk      (clk),
        .rstn     (rstn),
        .cap_en_i (m_if.req_en),
        .req_i    ('{m_if.req_mode, m_if.req_addr, m_if.req_wdata, m_if.req_wstrb}),
        .clr_i    (m_clr),
        .valid_o  (m_valid),
        .req_o    (m_slot)
    );

    // ---------------- arbiter state ----------------
    arb_state_t  state_q, state_d;
    req_id_t     last_grant_q, last_grant_d;
    req_id_t     grant_id_q, grant_id_d;
    mem_req_t    dreq_q, dreq_d;
    logic        dreq_en_q, dreq_en_d;
    logic        f_resp_en_q, f_resp_en_d;
    logic        m_resp_en_q, m_resp_en_d;
    logic [31:0] f_resp_data_q, f_resp_data_d;
    logic [31:0] m_resp_data_q, m_resp_data_d;
`ifdef ARB_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        f_err_q, f_err_d;
    logic        m_err_q, m_err_d;
    logic        done_err;
`endif

    req_id_t     winner;
    logic        done;
    logic [31:0] done_data;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= IDLE;
            last_grant_q  <= REQ_MEM;  // fetch wins the first tie
            grant_id_q    <= REQ_FETCH;
            dreq_q        <= '0;
            dreq_en_q     <= 1'b0;
            f_resp_en_q   <= 1'b0;
            m_resp_en_q   <= 1'b0;
            f_resp_data_q <= '0;
            m_resp_data_q <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q         <= '0;
            f_err_q       <= 1'b0;
            m_err_q       <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            grant_id_q    <= grant_id_d;
            dreq_q        <= dreq_d;
            dreq_en_q     <= dreq_en_d;
            f_resp_en_q   <= f_resp_en_d;
            m_resp_en_q   <= m_resp_en_d;
            f_resp_data_q <= f_resp_data_d;
            m_resp_data_q <= m_resp_data_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q         <= cnt_d;
            f_err_q       <= f_err_d;
            m_err_q       <= m_err_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        grant_id_d    = grant_id_q;
        dreq_d        = dreq_q;
        dreq_en_d     = 1'b0;
        f_resp_en_d   = 1'b0;
        m_resp_en_d   = 1'b0;
        f_resp_data_d = f_resp_data_q;
        m_resp_data_d = m_resp_data_q;
        f_clr         = 1'b0;
        m_clr         = 1'b0;
        winner        = REQ_FETCH;
        done          = 1'b0;
        done_data     = '0;
`ifdef ARB_TIMEOUT_EN
        cnt_d         = cnt_q;
        f_err_d       = 1'b0;
        m_err_d       = 1'b0;
        done_err      = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (f_valid || m_valid) begin
                    winner       = arb_pick(FIXED_PRIO != 0, f_valid, m_valid, last_grant_q);
                    dreq_d       = (winner == REQ_MEM) ? m_slot : f_slot;
                    dreq_en_d    = 1'b1;
                    last_grant_d = winner;
                    grant_id_d   = winner;
                    state_d      = WAIT_RESP;
`ifdef ARB_TIMEOUT_EN
                    cnt_d        = '0;
`endif
                end
            end
            WAIT_RESP: begin
                if (d_if.resp_en) begin
                    done      = 1'b1;
                    done_data = d_if.resp_data;
                end
`ifdef ARB_TIMEOUT_EN
                // A real response in the same cycle takes precedence.
                else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    done     = 1'b1;
                    done_err = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
                if (done) begin
                    state_d = IDLE;
                    if (grant_id_q == REQ_MEM) begin
                        m_resp_en_d   = 1'b1;
                        m_resp_data_d = done_data;
                        m_clr         = 1'b1;
`ifdef ARB_TIMEOUT_EN
                        m_err_d       = done_err;
`endif
                    end else begin
                        f_resp_en_d   = 1'b1;
                        f_resp_data_d = done_data;
                        f_clr         = 1'b1;
`ifdef ARB_TIMEOUT_EN
                        f_err_d       = done_err;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    assign f_if.pending   = f_valid;
    assign f_if.resp_en   = f_resp_en_q;
    assign f_if.resp_data = f_resp_data_q;
    assign m_if.pending   = m_valid;
    assign m_if.resp_en   = m_resp_en_q;
    assign m_if.resp_data = m_resp_data_q;
`ifdef ARB_TIMEOUT_EN
    assign f_if.resp_err  = f_err_q;
    assign m_if.resp_err  = m_err_q;
`endif

    assign d_if.req_en    = dreq_en_q;
    assign d_if.req_mode  = dreq_q.mode;
    assign d_if.req_addr  = dreq_q.addr;
    assign d_if.req_wdata = dreq_q.wdata;
    assign d_if.req_wstrb = dreq_q.wstrb;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter
//   Two arbiters (round-robin and fixed-priority) driven by identical
//   requester/downstream stimulus. Directed scenarios check specific values;
//   a randomized run is compared cycle by cycle against a reference model
//   built from the arbitration rules.
module tb_mem_req_arbiter;
    import mem_req_arbiter_pkg::*;

`ifdef ARB_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 1024;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic        f_en = 1'b0, f_mode = 1'b0, m_en = 1'b0, m_mode = 1'b0, dr_en = 1'b0;
    logic [31:0] f_addr = '0, f_wdata = '0, m_addr = '0, m_wdata = '0, dr_data = '0;
    logic [3:0]  f_wstrb = '0, m_wstrb = '0;

    int checks = 0;
    int errors = 0;

    mem_req_arbiter_if f0(), m0(), d0(), f1(), m1(), d1();

    always_comb begin
        f0.req_en = f_en; f0.req_mode = f_mode; f0.req_addr = f_addr; f0.req_wdata = f_wdata; f0.req_wstrb = f_wstrb;
        f1.req_en = f_en; f1.req_mode = f_mode; f1.req_addr = f_addr; f1.req_wdata = f_wdata; f1.req_wstrb = f_wstrb;
        m0.req_en = m_en; m0.req_mode = m_mode; m0.req_addr = m_addr; m0.req_wdata = m_wdata; m0.req_wstrb = m_wstrb;
        m1.req_en = m_en; m1.req_mode = m_mode; m1.req_addr = m_addr; m1.req_wdata = m_wdata; m1.req_wstrb = m_wstrb;
        d0.resp_en = dr_en; d0.resp_data = dr_data; d0.pending = 1'b0;
        d1.resp_en = dr_en; d1.resp_data = dr_data; d1.pending = 1'b0;
`ifdef ARB_TIMEOUT_EN
        d0.resp_err = 1'b0; d1.resp_err = 1'b0;
`endif
    end

    mem_req_arbiter #(.FIXED_PRIO(0), .TIMEOUT_CYCLES(TO)) u_rr (
        .clk(clk), .rstn(rstn), .f_if(f0), .m_if(m0), .d_if(d0));
    mem_req_arbiter #(.FIXED_PRIO(1), .TIMEOUT_CYCLES(TO)) u_fp (
        .clk(clk), .rstn(rstn), .f_if(f1), .m_if(m1), .d_if(d1));

    // Per-DUT views (index 0 = round-robin, 1 = fixed priority).
    logic [1:0]  o_dreq, o_fpend, o_mpend, o_fresp, o_mresp;
    logic [31:0] o_fdata [2];
    logic [31:0] o_mdata [2];
    mem_req_t    o_dfld  [2];
`ifdef ARB_TIMEOUT_EN
    logic [1:0]  o_ferr, o_merr;
`endif
    always_comb begin
        o_dreq  = {d1.req_en, d0.req_en};
        o_fpend = {f1.pending, f0.pending};
        o_mpend = {m1.pending, m0.pending};
        o_fresp = {f1.resp_en, f0.resp_en};
        o_mresp = {m1.resp_en, m0.resp_en};
        o_fdata[0] = f0.resp_data; o_fdata[1] = f1.resp_data;
        o_mdata[0] = m0.resp_data; o_mdata[1] = m1.resp_data;
        o_dfld[0] = '{d0.req_mode, d0.req_addr, d0.req_wdata, d0.req_wstrb};
        o_dfld[1] = '{d1.req_mode, d1.req_addr, d1.req_wdata, d1.req_wstrb};
`ifdef ARB_TIMEOUT_EN
        o_ferr = {f1.resp_err, f0.resp_err};
        o_merr = {m1.resp_err, m0.resp_err};
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        f_en = 1'b0; m_en = 1'b0; dr_en = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    // Reset state, with request/response noise held on during reset.
    task automatic test_reset();
        rstn = 1'b0;
        f_en = 1'b1; m_en = 1'b1; f_addr = 32'h1234; dr_en = 1'b1; dr_data = 32'hFFFF_FFFF;
        tick();
        tick();
        checks++; if ({o_fpend, o_mpend} !== 4'b0) begin errors++; $display("FAIL reset_pending got %b exp 0000", {o_fpend, o_mpend}); end
        checks++; if ({o_dreq, o_fresp, o_mresp} !== 6'b0) begin errors++; $display("FAIL reset_en got %b exp 000000", {o_dreq, o_fresp, o_mresp}); end
        checks++; if (d0.req_addr !== 32'h0 || f0.resp_data !== 32'h0 || m1.resp_data !== 32'h0) begin
            errors++; $display("FAIL reset_data addr %h fdata %h mdata %h exp 0", d0.req_addr, f0.resp_data, m1.resp_data); end
        clear_inputs();
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_single_fetch();
        do_reset();
        f_en = 1'b1; f_mode = MEMREQ_READ; f_addr = 32'h0000_1000; f_wdata = '0; f_wstrb = '0;
        tick();
        f_en = 1'b0;
        checks++; if (f0.pending !== 1'b1 || d0.req_en !== 1'b0) begin errors++; $display("FAIL sf_capture pend %b dreq %b exp 1 0", f0.pending, d0.req_en); end
        tick();
        checks++; if (d0.req_en !== 1'b1 || d0.req_addr !== 32'h1000 || d0.req_mode !== MEMREQ_READ) begin
            errors++; $display("FAIL sf_grant en %b addr %h mode %b exp 1 00001000 0", d0.req_en, d0.req_addr, d0.req_mode); end
        tick();
        checks++; if (d0.req_en !== 1'b0) begin errors++; $display("FAIL sf_pulse got %b exp 0", d0.req_en); end
        tick();
        dr_en = 1'b1; dr_data = 32'hDEAD_BEEF;
        tick();
        dr_en = 1'b0;
        checks++; if (f0.resp_en !== 1'b1 || f0.resp_data !== 32'hDEAD_BEEF || m0.resp_en !== 1'b0 || f0.pending !== 1'b0) begin
            errors++; $display("FAIL sf_resp fen %b data %h men %b pend %b exp 1 deadbeef 0 0", f0.resp_en, f0.resp_data, m0.resp_en, f0.pending); end
        tick();
        checks++; if (f0.resp_en !== 1'b0 || f0.resp_data !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL sf_hold fen %b data %h exp 0 deadbeef", f0.resp_en, f0.resp_data); end
    endtask

    // Simultaneous requests three times: RR gives f,m,f,m,f,m; fixed gives m,f each round.
    task automatic test_back_to_back();
        logic [31:0] fa, ma, rd;
        do_reset();
        for (int r = 0; r < 3; r++) begin
            fa = 32'h1000 + 32'(r * 16); ma = 32'h2000 + 32'(r * 16);
            f_en = 1'b1; f_mode = MEMREQ_READ; f_addr = fa;
            m_en = 1'b1; m_mode = MEMREQ_READ; m_addr = ma;
            tick();
            f_en = 1'b0; m_en = 1'b0;
            for (int g = 0; g < 2; g++) begin
                for (int n = 0; n < 5 && d0.req_en !== 1'b1; n++) tick();
                checks++; if (d0.req_en !== 1'b1 || d1.req_en !== 1'b1) begin
                    errors++; $display("FAIL b2b_grant_seen r%0d g%0d got %b%b exp 11", r, g, d1.req_en, d0.req_en); end
                checks++; if (d0.req_addr !== (g == 0 ? fa : ma) || d1.req_addr !== (g == 0 ? ma : fa)) begin
                    errors++; $display("FAIL b2b_order r%0d g%0d rr %h fp %h exp %h %h", r, g, d0.req_addr, d1.req_addr,
                                       (g == 0 ? fa : ma), (g == 0 ? ma : fa)); end
                tick();
                rd = 32'hA000_0000 + 32'(r * 2 + g);
                dr_en = 1'b1; dr_data = rd;
                tick();
                dr_en = 1'b0;
                checks++; if ({f0.resp_en, m0.resp_en, f1.resp_en, m1.resp_en} !== (g == 0 ? 4'b1001 : 4'b0110)) begin
                    errors++; $display("FAIL b2b_route r%0d g%0d got %b exp %b", r, g,
                                       {f0.resp_en, m0.resp_en, f1.resp_en, m1.resp_en}, (g == 0 ? 4'b1001 : 4'b0110)); end
                checks++; if ((g == 0 ? f0.resp_data : m0.resp_data) !== rd) begin
                    errors++; $display("FAIL b2b_data r%0d g%0d got %h exp %h", r, g, (g == 0 ? f0.resp_data : m0.resp_data), rd); end
            end
        end
    endtask

    task automatic test_mem_write();
        do_reset();
        m_en = 1'b1; m_mode = MEMREQ_WRITE; m_addr = 32'h80; m_wdata = 32'h1234_5678; m_wstrb = 4'b0011;
        tick();
        m_en = 1'b0;
        tick();
        checks++; if (d0.req_en !== 1'b1 || d0.req_mode !== MEMREQ_WRITE || d0.req_addr !== 32'h80 ||
                      d0.req_wdata !== 32'h1234_5678 || d0.req_wstrb !== 4'b0011) begin
            errors++; $display("FAIL wr_fields en %b mode %b addr %h wdata %h wstrb %b exp 1 1 00000080 12345678 0011",
                               d0.req_en, d0.req_mode, d0.req_addr, d0.req_wdata, d0.req_wstrb); end
        checks++; if (f0.pending !== 1'b0 || m0.pending !== 1'b1) begin
            errors++; $display("FAIL wr_pending f %b m %b exp 0 1", f0.pending, m0.pending); end
        tick();
        dr_en = 1'b1; dr_data = 32'h0BAD_F00D;
        tick();
        dr_en = 1'b0;
        checks++; if (m0.resp_en !== 1'b1 || f0.resp_en !== 1'b0 || m0.pending !== 1'b0 || f0.pending !== 1'b0) begin
            errors++; $display("FAIL wr_resp men %b fen %b mpend %b fpend %b exp 1 0 0 0", m0.resp_en, f0.resp_en, m0.pending, f0.pending); end
    endtask

    task automatic test_dup_drop();
        int nreq, nresp;
        do_reset();
        nreq = 0; nresp = 0;
        f_mode = MEMREQ_READ;
        for (int i = 0; i < 12; i++) begin
            f_en = (i == 0 || i == 1 || i == 3);
            f_addr = 32'h300 + 32'(i);
            dr_en = (i == 5); dr_data = 32'h55;
            tick();
            nreq += int'(d0.req_en);
            nresp += int'(f0.resp_en);
        end
        clear_inputs();
        checks++; if (nreq != 1 || nresp != 1) begin errors++; $display("FAIL dup_counts dreq %0d resp %0d exp 1 1", nreq, nresp); end
        checks++; if (d0.req_addr !== 32'h300 || f0.pending !== 1'b0) begin
            errors++; $display("FAIL dup_first addr %h pend %b exp 00000300 0", d0.req_addr, f0.pending); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        f_en = 1'b1; f_mode = MEMREQ_READ; f_addr = 32'h500;
        tick();
        f_en = 1'b0;
        tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        dr_en = 1'b1; dr_data = 32'h7777_7777;
        tick();
        dr_en = 1'b0;
        tick();
        checks++; if ({o_fresp, o_mresp, o_fpend, o_mpend, o_dreq} !== 10'b0) begin
            errors++; $display("FAIL rmid_quiet got %b exp 0", {o_fresp, o_mresp, o_fpend, o_mpend, o_dreq}); end
        m_en = 1'b1; m_mode = MEMREQ_READ; m_addr = 32'h600;
        tick();
        m_en = 1'b0;
        tick();
        checks++; if (d0.req_en !== 1'b1 || d0.req_addr !== 32'h600) begin
            errors++; $display("FAIL rmid_fresh en %b addr %h exp 1 00000600", d0.req_en, d0.req_addr); end
        dr_en = 1'b1; dr_data = 32'h6666_0001;
        tick();
        dr_en = 1'b0;
        checks++; if (m0.resp_en !== 1'b1 || m0.resp_data !== 32'h6666_0001) begin
            errors++; $display("FAIL rmid_resp en %b data %h exp 1 66660001", m0.resp_en, m0.resp_data); end
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        do_reset();
        m_en = 1'b1; m_mode = MEMREQ_READ; m_addr = 32'h40;
        tick();
        m_en = 1'b0;
        tick();
        tick();
        dr_en = 1'b1; dr_data = 32'hCAFE_F00D;
        tick();
        dr_en = 1'b0;
        checks++; if (m0.resp_en !== 1'b1 || m0.resp_err !== 1'b0 || m0.resp_data !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL to_normal en %b err %b data %h exp 1 0 cafef00d", m0.resp_en, m0.resp_err, m0.resp_data); end
        m_en = 1'b1;
        tick();
        m_en = 1'b0;
        tick();
        checks++; if (d0.req_en !== 1'b1) begin errors++; $display("FAIL to_grant got %b exp 1", d0.req_en); end
        n = 0;
        while (m0.resp_en !== 1'b1 && n < 20) begin tick(); n++; end
        checks++; if (n != 8) begin errors++; $display("FAIL to_latency got %0d exp 8", n); end
        checks++; if (m0.resp_err !== 1'b1 || m0.resp_data !== 32'h0 || m0.pending !== 1'b0) begin
            errors++; $display("FAIL to_flags err %b data %h pend %b exp 1 0 0", m0.resp_err, m0.resp_data, m0.pending); end
        dr_en = 1'b1; dr_data = 32'h1111_2222;
        tick();
        dr_en = 1'b0;
        checks++; if (m0.resp_en !== 1'b0 || f0.resp_en !== 1'b0 || m0.resp_data !== 32'h0) begin
            errors++; $display("FAIL to_late men %b fen %b data %h exp 0 0 0", m0.resp_en, f0.resp_en, m0.resp_data); end
        f_en = 1'b1; f_addr = 32'h44;
        tick();
        f_en = 1'b0;
        tick();
        checks++; if (d0.req_en !== 1'b1 || d0.req_addr !== 32'h44) begin
            errors++; $display("FAIL to_idle en %b addr %h exp 1 00000044", d0.req_en, d0.req_addr); end
        dr_en = 1'b1;
        tick();
        dr_en = 1'b0;
    endtask
`endif

    // Randomized traffic against a transaction-rule model for both DUTs.
    task automatic test_random();
        bit          v     [2][2];
        mem_req_t    slot  [2][2];
        logic [31:0] rd    [2][2];
        bit          busy  [2];
        int          gid   [2];
        int          lg    [2];
        int          wcnt  [2];
        bit          e_dreq[2];
        mem_req_t    e_fld [2];
        bit          e_resp[2][2];
        bit          e_err [2];
        bit          nv    [2];
        int          w;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            v[k][0] = 0; v[k][1] = 0; busy[k] = 0; lg[k] = 1; gid[k] = 0; wcnt[k] = 0;
            rd[k][0] = '0; rd[k][1] = '0; slot[k][0] = '0; slot[k][1] = '0;
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            f_en = ($urandom_range(0, 2) == 0); f_mode = 1'($urandom); f_addr = $urandom; f_wdata = $urandom; f_wstrb = 4'($urandom);
            m_en = ($urandom_range(0, 2) == 0); m_mode = 1'($urandom); m_addr = $urandom; m_wdata = $urandom; m_wstrb = 4'($urandom);
            dr_en = busy[0] ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
            dr_data = $urandom;
            for (int k = 0; k < 2; k++) begin
                e_dreq[k] = 0; e_fld[k] = '0; e_resp[k][0] = 0; e_resp[k][1] = 0; e_err[k] = 0;
                nv[0] = v[k][0]; nv[1] = v[k][1];
                if (!busy[k]) begin
                    if (v[k][0] || v[k][1]) begin
                        if (k == 1)                  w = v[k][1] ? 1 : 0;
                        else if (v[k][0] && v[k][1]) w = 1 - lg[k];
                        else                         w = v[k][1] ? 1 : 0;
                        e_dreq[k] = 1; e_fld[k] = slot[k][w];
                        lg[k] = w; gid[k] = w; busy[k] = 1; wcnt[k] = 0;
                    end
                end else if (dr_en) begin
                    e_resp[k][gid[k]] = 1; rd[k][gid[k]] = dr_data; nv[gid[k]] = 0; busy[k] = 0;
                end
`ifdef ARB_TIMEOUT_EN
                else if (wcnt[k] == TO - 1) begin
                    e_resp[k][gid[k]] = 1; e_err[k] = 1; rd[k][gid[k]] = '0; nv[gid[k]] = 0; busy[k] = 0;
                end else wcnt[k]++;
`endif
                if (f_en && !v[k][0]) begin nv[0] = 1; slot[k][0] = '{f_mode, f_addr, f_wdata, f_wstrb}; end
                if (m_en && !v[k][1]) begin nv[1] = 1; slot[k][1] = '{m_mode, m_addr, m_wdata, m_wstrb}; end
                v[k][0] = nv[0]; v[k][1] = nv[1];
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++; if (o_dreq[k] !== e_dreq[k] || (e_dreq[k] && o_dfld[k] !== e_fld[k])) begin
                    errors++; $display("FAIL rnd_dreq dut%0d cyc%0d en %b fld %h exp %b %h", k, cyc, o_dreq[k], o_dfld[k], e_dreq[k], e_fld[k]); end
                checks++; if (o_fresp[k] !== e_resp[k][0] || o_mresp[k] !== e_resp[k][1] ||
                              o_fdata[k] !== rd[k][0] || o_mdata[k] !== rd[k][1]) begin
                    errors++; $display("FAIL rnd_resp dut%0d cyc%0d en %b%b data %h %h exp %b%b %h %h", k, cyc, o_fresp[k], o_mresp[k],
                                       o_fdata[k], o_mdata[k], e_resp[k][0], e_resp[k][1], rd[k][0], rd[k][1]); end
                checks++; if (o_fpend[k] !== v[k][0] || o_mpend[k] !== v[k][1]) begin
                    errors++; $display("FAIL rnd_pend dut%0d cyc%0d got %b%b exp %b%b", k, cyc, o_fpend[k], o_mpend[k], v[k][0], v[k][1]); end
`ifdef ARB_TIMEOUT_EN
                checks++; if (o_ferr[k] !== (e_resp[k][0] & e_err[k]) || o_merr[k] !== (e_resp[k][1] & e_err[k])) begin
                    errors++; $display("FAIL rnd_err dut%0d cyc%0d got %b%b exp %b%b", k, cyc, o_ferr[k], o_merr[k],
                                       e_resp[k][0] & e_err[k], e_resp[k][1] & e_err[k]); end
`endif
            end
        end
        clear_inputs();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_fetch();
        test_back_to_back();
        test_mem_write();
        test_dup_drop();
        test_reset_mid();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
